// File: rtl/fixed_dot_product_accum.sv
// fixed_dot_product_accum: streaming fixed-point dot product; in: clk, rst, data_in/weight beats with valid/ready; out: data_out scalar with valid/ready
module fixed_dot_product_accum #(
  parameter int IN_WIDTH = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int IN_SIZE = 4,
  parameter int IN_DEPTH = 4,
  parameter int SIGNED = 1,
  parameter int OUT_WIDTH = IN_WIDTH + WEIGHT_WIDTH + $clog2(IN_SIZE * IN_DEPTH)
) (
  input  logic clk,
  input  logic rst,
  input  logic [IN_SIZE-1:0][IN_WIDTH-1:0] data_in,
  input  logic data_in_valid,
  output logic data_in_ready,
  input  logic [IN_SIZE-1:0][WEIGHT_WIDTH-1:0] weight,
  input  logic weight_valid,
  output logic weight_ready,
  output logic [OUT_WIDTH-1:0] data_out,
  output logic data_out_valid,
  input  logic data_out_ready
);
  localparam int PW = IN_WIDTH + WEIGHT_WIDTH;
  localparam int CW = IN_DEPTH > 1 ? $clog2(IN_DEPTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(IN_DEPTH - 1);
  logic en, fire, load, s1_valid, s1_first, s1_last;
  logic [CW-1:0] cnt;
  logic [IN_SIZE-1:0][PW-1:0] prod, s1_prod;
  logic [IN_SIZE-1:0][OUT_WIDTH-1:0] ext;
  logic [OUT_WIDTH-1:0] acc, beat_sum, acc_next;
  assign en = !rst && !(data_out_valid && !data_out_ready);
  assign data_in_ready = en;
  assign weight_ready = en;
  assign fire = data_in_valid && weight_valid && en;
  for (genvar i = 0; i < IN_SIZE; i++) begin : g_lane
    if (SIGNED != 0) begin : g_s
      assign prod[i] = PW'($signed(data_in[i])) * PW'($signed(weight[i]));
      assign ext[i] = OUT_WIDTH'($signed(s1_prod[i]));
    end else begin : g_u
      assign prod[i] = PW'(data_in[i]) * PW'(weight[i]);
      assign ext[i] = OUT_WIDTH'(s1_prod[i]);
    end
  end
  always_comb begin
    beat_sum = '0;
    for (int i = 0; i < IN_SIZE; i++) beat_sum = beat_sum + ext[i];
  end
  assign acc_next = (s1_first ? '0 : acc) + beat_sum;
  assign load = en && s1_valid && s1_last;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last <= 1'b0;
      s1_prod <= '0;
      acc <= '0;
      data_out <= '0;
      data_out_valid <= 1'b0;
    end else begin
      if (en) begin
        s1_valid <= fire;
        s1_first <= cnt == '0;
        s1_last <= cnt == LAST;
        s1_prod <= prod;
        if (fire) cnt <= cnt == LAST ? '0 : cnt + 1'b1;
      end
      if (en && s1_valid) acc <= acc_next;
      if (load) data_out <= acc_next;
      data_out_valid <= load || (data_out_valid && !data_out_ready);
    end
  end
endmodule

// File: tb/tb_fixed_dot_product_accum.sv
// tb_fixed_dot_product_accum: randomized self-checking bench for signed, unsigned and single-beat dot product instances
module tb_fixed_dot_product_accum;
  logic clk = 0, rst = 1, data_in_valid = 0, weight_valid = 0, dor = 1;
  logic [31:0] d_in = '0, w_in = '0;
  logic rdy[3], wrdy[3], dv[3];
  longint dout[3];
  longint q[3][$];
  longint cur[3], held[3];
  int cnt[3];
  bit hold[3], prev_rst = 0, stop = 0;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int DEP = g == 2 ? 1 : 4;
    localparam int SG = g == 1 ? 0 : 1;
    localparam int OW = 16 + $clog2(4 * DEP);
    logic [OW-1:0] o;
    fixed_dot_product_accum #(.IN_WIDTH(8), .WEIGHT_WIDTH(8), .IN_SIZE(4), .IN_DEPTH(DEP), .SIGNED(SG)) u_dut (
      .clk(clk), .rst(rst),
      .data_in(d_in), .data_in_valid(data_in_valid), .data_in_ready(rdy[g]),
      .weight(w_in), .weight_valid(weight_valid), .weight_ready(wrdy[g]),
      .data_out(o), .data_out_valid(dv[g]), .data_out_ready(dor)
    );
    if (SG == 1) begin : g_s
      assign dout[g] = longint'($signed(o));
    end else begin : g_u
      assign dout[g] = longint'(o);
    end
  end
  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", tag, obs, exp, $time);
    end
  endtask
  function automatic longint dot(input logic [31:0] d, input logic [31:0] w, input bit s);
    longint r = 0;
    logic [7:0] a, b;
    for (int i = 0; i < 4; i++) begin
      a = d[i*8+:8];
      b = w[i*8+:8];
      r += s ? longint'($signed(a)) * longint'($signed(b)) : longint'(a) * longint'(b);
    end
    return r;
  endfunction
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (prev_rst) begin
        chk("rst_valid", dv[k], 0);
        chk("rst_data", dout[k], 0);
      end
      chk("in_ready", rdy[k], !rst && !(dv[k] && !dor));
      chk("w_ready", wrdy[k], !rst && !(dv[k] && !dor));
      if (hold[k] && dv[k]) chk("stable", dout[k], held[k]);
      hold[k] = dv[k] && !dor;
      held[k] = dout[k];
      if (dv[k]) begin
        if (q[k].size() == 0) chk("spurious", dv[k], 0);
        else begin
          chk($sformatf("result%0d", k), dout[k], q[k][0]);
          if (dor) void'(q[k].pop_front());
        end
      end
      if (rst) begin
        cur[k] = 0;
        cnt[k] = 0;
        q[k].delete();
      end else if (data_in_valid && weight_valid && rdy[k]) begin
        cur[k] += dot(d_in, w_in, k != 1);
        cnt[k]++;
        if (cnt[k] == (k == 2 ? 1 : 4)) begin
          q[k].push_back(cur[k]);
          cur[k] = 0;
          cnt[k] = 0;
        end
      end
    end
    prev_rst = rst;
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic beat(input logic [31:0] d, input logic [31:0] w, input int lag, input int gap);
    int n = 0;
    repeat (gap) step();
    d_in = d;
    data_in_valid = 1;
    if (lag > 0) begin
      weight_valid = 0;
      repeat (lag) step();
    end
    w_in = w;
    weight_valid = 1;
    do begin
      @(negedge clk);
      n++;
    end while (!rdy[0] && n < 200);
    if (n >= 200) chk("fire_timeout", rdy[0], 1);
    step();
    data_in_valid = 0;
    weight_valid = 0;
  endtask
  task automatic drain();
    int n = 0;
    while ((q[0].size() + q[1].size() + q[2].size()) != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain", q[0].size() + q[1].size() + q[2].size(), 0);
    step();
  endtask
  initial begin
    int n;
    repeat (3) step();
    rst = 0;
    repeat (4) beat(32'h01010101, 32'h01010101, 0, 0);
    @(negedge clk) chk("lat_early", dv[0], 0);
    @(negedge clk) begin
      chk("lat_valid", dv[0], 1);
      chk("all_ones", dout[0], 16);
    end
    @(negedge clk) chk("one_pulse", dv[0], 0);
    step();
    repeat (4) beat(32'h80808080, 32'h80808080, 0, 0);
    repeat (4) beat(32'h7f7f7f7f, 32'h80808080, 0, 0);
    repeat (4) beat(32'hffffffff, 32'hffffffff, 0, 0);
    drain();
    dor = 0;
    fork
      repeat (12) beat($urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 2));
      begin
        int m = 0;
        while (!dv[0] && m < 500) begin
          @(negedge clk);
          m++;
        end
        chk("bp_first", dv[0], 1);
        repeat (10) step();
        dor = 1;
      end
    join
    drain();
    repeat (2) beat(32'h05050505, 32'h05050505, 0, 0);
    rst = 1;
    step();
    rst = 0;
    repeat (4) beat(32'h01010101, 32'h02020202, 0, 0);
    n = 0;
    while (!dv[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid", dout[0], 32);
    step();
    drain();
    fork
      begin
        int m = 0;
        do begin
          @(negedge clk);
          m++;
        end while (!(data_in_valid && weight_valid && rdy[2]) && m < 50);
        repeat (2) @(negedge clk);
        chk("d1_valid", dv[2], 1);
        chk("d1_value", dout[2], 10);
      end
      repeat (6) beat(32'h04030201, 32'h01010101, 0, 0);
    join
    drain();
    stop = 0;
    fork
      begin
        repeat (120) beat($urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 2));
        stop = 1;
      end
      begin
        while (!stop) begin
          step();
          dor = $urandom_range(0, 3) != 0;
        end
        dor = 1;
      end
    join
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
